// File: rtl/regfile_dump.sv
// Streams a contiguous (possibly wrapping) range of register-file entries
// out over a valid/ready port while holding the core's register writes off.
module regfile_dump #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [AW-1:0]   first_reg,
  input  logic [AW-1:0]   last_reg,
  output logic [AW-1:0]   rs,
  input  logic [XLEN-1:0] regdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [AW-1:0]   out_index,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] last_q;
  logic          handshake;

  assign handshake = out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first keeps every path driven, so no latch
  // is inferred for state_nxt.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    state_nxt = SEND;
      SEND:    if (handshake) state_nxt = out_last ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rs itself remembers the current position, so only the end of the range
  // needs latching; the wrap falls out of AW-bit modular increment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rs        <= '0;
      last_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rs     <= first_reg;
            last_q <= last_reg;
          end
        end
        READ: begin
          out_data  <= regdata;
          out_index <= rs;
          out_last  <= (rs == last_q);
          out_valid <= 1'b1;
        end
        SEND: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (!out_last) rs <= rs + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed and randomized dumps of a behavioural register file, compared
// word by word against the expected index sequence for each range.
module tb_regfile_dump;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   first_reg = '0;
  logic [AW-1:0]   last_reg = '0;
  logic [AW-1:0]   rs;
  logic [XLEN-1:0] regdata;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_data;
  logic [AW-1:0]   out_index;
  logic            out_last;
  logic            busy;
  logic            done;

  logic [XLEN-1:0] regs [NREG];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign regdata = regs[rs];

  regfile_dump #(.XLEN(XLEN), .AW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .rs        (rs),
    .regdata   (regdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"},  out_data,  0);
    check({tag, "_index"}, out_index, 0);
    check({tag, "_last"},  out_last,  0);
    check({tag, "_busy"},  busy,      0);
    check({tag, "_done"},  done,      0);
    check({tag, "_rs"},    rs,        0);
  endtask

  // Called at a negedge while idle: start is sampled at the coming posedge.
  task automatic kick(input int f, input int l);
    start     = 1'b1;
    first_reg = AW'(f);
    last_reg  = AW'(l);
    @(negedge clock);
    start     = 1'b0;
    first_reg = AW'($urandom);
    last_reg  = AW'($urandom);
    check("kick_busy",  busy,      1);
    check("kick_valid", out_valid, 0);
    check("kick_rs",    rs,        f % NREG);
    check("kick_done",  done,      0);
  endtask

  // One word: appears one cycle after its read cycle, held through stalls.
  task automatic word(input int idx, input bit lst, input int stall, input bit inject);
    int cyc = 0;
    while (out_valid !== 1'b1 && cyc < 8) begin
      @(negedge clock);
      cyc++;
    end
    check("word_valid", out_valid, 1);
    check("word_gap",   cyc,       1);
    check("word_index", out_index, idx);
    check("word_data",  out_data,  regs[idx]);
    check("word_last",  out_last,  lst);
    check("word_busy",  busy,      1);
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      if (inject) begin
        start     = 1'b1;
        first_reg = AW'(5);
        last_reg  = AW'(7);
      end
      @(negedge clock);
      start = 1'b0;
      check("stall_valid", out_valid, 1);
      check("stall_index", out_index, idx);
      check("stall_data",  out_data,  regs[idx]);
      check("stall_last",  out_last,  lst);
    end
    out_ready = 1'b1;
    @(negedge clock);
    if (stall != 0) out_ready = 1'b0;
    check("accept_drop", out_valid, 0);
    if (!lst) check("accept_rs", rs, (idx + 1) % NREG);
  endtask

  task automatic collect(input int f, input int l, input int stall, input bit inject);
    int n = ((l - f) % NREG + NREG) % NREG + 1;
    for (int k = 0; k < n; k++)
      word((f + k) % NREG, k == n - 1, stall, inject && k == 0);
    check("done_pulse", done, 1);
    check("done_busy",  busy, 1);
    @(negedge clock);
    out_ready = 1'b0;
    check("after_done", done,      0);
    check("after_busy", busy,      0);
    check("after_vld",  out_valid, 0);
    @(negedge clock);
    check("idle_busy",  busy,      0);
    check("idle_done",  done,      0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREG; i++) regs[i] = $urandom;
    regs[0]  = '0;
    regs[1]  = 32'h12345678;
    regs[2]  = 32'h87654321;
    regs[3]  = 32'hFFFFFFFF;
    regs[31] = 32'hA5A5A5A5;

    // Reset asserted mid low phase must clear outputs before any edge.
    #13 reset = 1'b0;
    #1 chk_zero("rst_async");
    repeat (2) @(negedge clock);
    chk_zero("rst_hold");
    reset = 1'b1;
    @(negedge clock);
    chk_zero("rst_release");

    // Single word.
    out_ready = 1'b1;
    kick(1, 1);
    collect(1, 1, 0, 0);

    // Range 1..3 with three stall cycles per word.
    kick(1, 3);
    collect(1, 3, 3, 0);

    // Wrap through register 0.
    out_ready = 1'b1;
    kick(31, 0);
    collect(31, 0, 0, 0);

    // Start pulses while busy are ignored.
    kick(1, 3);
    collect(1, 3, 2, 1);

    // Randomized ranges and stall patterns.
    for (int t = 0; t < 6; t++) begin
      int f  = $urandom_range(NREG - 1);
      int l  = $urandom_range(NREG - 1);
      int st = $urandom_range(2);
      out_ready = (st == 0);
      kick(f, l);
      collect(f, l, st, 0);
    end

    // Reset while the fifth word of a full dump is presented.
    out_ready = 1'b1;
    kick(0, 31);
    for (int k = 0; k < 4; k++) word(k, 1'b0, 0, 1'b0);
    out_ready = 1'b0;
    @(negedge clock);
    check("mid_valid", out_valid, 1);
    check("mid_index", out_index, 4);
    #2 reset = 1'b0;
    #1 chk_zero("mid_rst");
    repeat (2) @(negedge clock);
    chk_zero("mid_hold");

    // Start presented with the release is taken on the first edge.
    reset     = 1'b1;
    out_ready = 1'b1;
    kick(2, 2);
    collect(2, 2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
